// File: rtl/ham_secded_check_pipe.sv
// ham_secded_check_pipe: two-stage pipelined extended-Hamming SECDED checker
// with saturating error counters and a sticky first-fatal syndrome capture.
module ham_secded_check_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    localparam int CHK_W = $clog2(DATA_W + $clog2(DATA_W) + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CHK_W:0]    code_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CHK_W-1:0]  syndrome_o,
    output logic              error_o,
    output logic              fatal_o,
    input  logic              clr_i,
    output logic [CNT_W-1:0]  corr_cnt_o,
    output logic [CNT_W-1:0]  fatal_cnt_o,
    output logic              fatal_seen_o,
    output logic [CHK_W-1:0]  fatal_syn_o
);
    localparam logic [CHK_W-1:0] N_L = CHK_W'(DATA_W + CHK_W);

    // codeword position of data bit i: i-th non-power-of-two position from 3 upward
    function automatic int dpos(input int i);
        int k;
        dpos = 0;
        k = 0;
        for (int p = 3; p < 128; p++)
            if ((p & (p - 1)) != 0) begin
                if (k == i) dpos = p;
                k++;
            end
    endfunction

    logic              r_s1_valid, r_s1_pe;
    logic [DATA_W-1:0] r_s1_data;
    logic [CHK_W-1:0]  r_s1_syn;
    logic              r_valid, r_err, r_fatal;
    logic [DATA_W-1:0] r_data;
    logic [CHK_W-1:0]  r_syn;
    logic [CNT_W-1:0]  r_corr_cnt, r_fatal_cnt;
    logic              r_seen;
    logic [CHK_W-1:0]  r_seen_syn;

    logic              w_adv, w_xfer, w_pe, w_fatal;
    logic [CHK_W-1:0]  w_syn;
    logic [DATA_W-1:0] w_data;

    assign w_adv  = ~r_valid | ready_i;
    assign w_xfer = r_valid & ready_i;
    assign w_pe   = ^data_i ^ ^code_i;

    always_comb begin
        w_syn = code_i[CHK_W-1:0];
        for (int i = 0; i < DATA_W; i++)
            if (data_i[i]) w_syn = w_syn ^ CHK_W'(dpos(i));
    end

    always_comb begin
        w_data = r_s1_data;
        for (int i = 0; i < DATA_W; i++)
            if (r_s1_pe && r_s1_syn == CHK_W'(dpos(i))) w_data[i] = ~r_s1_data[i];
    end

    // power-of-two syndromes are always <= N, so only s>N needs the explicit test
    assign w_fatal = (r_s1_syn != '0) && (!r_s1_pe || r_s1_syn > N_L);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_pe    <= 1'b0;
            r_s1_data  <= '0;
            r_s1_syn   <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_fatal    <= 1'b0;
            r_data     <= '0;
            r_syn      <= '0;
        end else if (w_adv) begin
            r_s1_valid <= valid_i;
            r_s1_pe    <= w_pe;
            r_s1_data  <= data_i;
            r_s1_syn   <= w_syn;
            r_valid    <= r_s1_valid;
            r_err      <= (r_s1_syn != '0) | r_s1_pe;
            r_fatal    <= w_fatal;
            r_data     <= w_data;
            r_syn      <= r_s1_syn;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_corr_cnt  <= '0;
            r_fatal_cnt <= '0;
            r_seen      <= 1'b0;
            r_seen_syn  <= '0;
        end else if (clr_i) begin
            r_corr_cnt  <= '0;
            r_fatal_cnt <= '0;
            r_seen      <= 1'b0;
            r_seen_syn  <= '0;
        end else if (w_xfer) begin
            if (r_err && !r_fatal && r_corr_cnt != '1) r_corr_cnt <= r_corr_cnt + 1'b1;
            if (r_fatal && r_fatal_cnt != '1) r_fatal_cnt <= r_fatal_cnt + 1'b1;
            if (r_fatal && !r_seen) begin
                r_seen     <= 1'b1;
                r_seen_syn <= r_syn;
            end
        end
    end

    assign ready_o      = w_adv;
    assign valid_o      = r_valid;
    assign data_o       = r_data;
    assign syndrome_o   = r_syn;
    assign error_o      = r_err;
    assign fatal_o      = r_fatal;
    assign corr_cnt_o   = r_corr_cnt;
    assign fatal_cnt_o  = r_fatal_cnt;
    assign fatal_seen_o = r_seen;
    assign fatal_syn_o  = r_seen_syn;
endmodule
